// File: rtl/mul_div_pkg.sv
// Shared constants, FSM encoding and corner-case helper for the RV32M mul/div sequencer.
package mul_div_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] INT_MIN_32  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES_32 = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // RISC-V defined results: divide-by-zero wins over signed overflow.
    function automatic logic [31:0] corner_result(input logic        is_rem,
                                                  input logic [31:0] dividend,
                                                  input logic        dz);
        if (dz) begin
            return is_rem ? dividend : ALL_ONES_32;
        end
        return is_rem ? 32'h0000_0000 : INT_MIN_32;
    endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// Request/response and datapath handshake bundle for mul_div_seq.
// master = requester plus datapath side, slave = the sequencer.
interface mul_div_seq_if;

    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready;
    logic        done;
    logic [31:0] rd;
    logic        err;

    logic        md_enable_in;
    logic [31:0] md_x;
    logic [31:0] md_y;
    logic        md_mul0_div1;
    logic        md_x_signed0_unsigned1;
    logic        md_y_signed0_unsigned1;
    logic        md_enable_out;
    logic [63:0] md_z;
    logic        md_ov;

    modport master (
        output start, funct3, rs1, rs2, md_enable_out, md_z, md_ov,
        input  ready, done, rd, err, md_enable_in, md_x, md_y, md_mul0_div1,
               md_x_signed0_unsigned1, md_y_signed0_unsigned1
    );

    modport slave (
        input  start, funct3, rs1, rs2, md_enable_out, md_z, md_ov,
        output ready, done, rd, err, md_enable_in, md_x, md_y, md_mul0_div1,
               md_x_signed0_unsigned1, md_y_signed0_unsigned1
    );

endinterface

// File: rtl/mul_div_decode.sv
// Combinational funct3 decode into datapath controls and result-half select.
module mul_div_decode
    import mul_div_pkg::*;
(
    input  logic [2:0] i_funct3,
    output logic       o_mul0_div1,
    output logic       o_x_unsigned,
    output logic       o_y_unsigned,
    output logic       o_hi_sel
);

    always_comb begin
        o_mul0_div1  = i_funct3[2];
        o_x_unsigned = 1'b0;
        o_y_unsigned = 1'b0;
        o_hi_sel     = 1'b0;
        unique case (i_funct3)
            OP_MUL:    ;
            OP_MULH:   o_hi_sel = 1'b1;
            OP_MULHSU: begin
                o_y_unsigned = 1'b1;
                o_hi_sel     = 1'b1;
            end
            OP_MULHU:  begin
                o_x_unsigned = 1'b1;
                o_y_unsigned = 1'b1;
                o_hi_sel     = 1'b1;
            end
            // Divider packs {quotient, remainder}: quotient lives in the high word.
            OP_DIV:    o_hi_sel = 1'b1;
            OP_DIVU:   begin
                o_x_unsigned = 1'b1;
                o_y_unsigned = 1'b1;
                o_hi_sel     = 1'b1;
            end
            OP_REM:    ;
            OP_REMU:   begin
                o_x_unsigned = 1'b1;
                o_y_unsigned = 1'b1;
            end
            default:   ;
        endcase
    end

endmodule

// File: rtl/mul_div_seq.sv
// RV32M sequencer: accepts one op, issues it to mul_div_32, resolves corners, bounds the wait.
// Optional MUL_DIV_SEQ_FAST_CORNER_EN: divide-by-zero/overflow ops skip the datapath entirely.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 63,
    parameter int unsigned CNT_WIDTH      = 6
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_seq_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e               r_state, w_state_d;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
    logic [31:0]          r_rd, w_rd_d;
    logic                 r_err, w_err_d;
    logic                 w_accept;

    logic [31:0] r_x, r_y;
    logic        r_mul0_div1, r_x_unsigned, r_y_unsigned, r_hi_sel, r_is_rem;
    logic        r_dz, r_sov;

    logic        w_mul0_div1, w_x_unsigned, w_y_unsigned, w_hi_sel;
    logic        w_dz_in, w_sov_in;
    logic [31:0] w_dp_word, w_wait_result;
    logic        w_unused_ov;

    mul_div_decode u_decode (
        .i_funct3     (bus.funct3),
        .o_mul0_div1  (w_mul0_div1),
        .o_x_unsigned (w_x_unsigned),
        .o_y_unsigned (w_y_unsigned),
        .o_hi_sel     (w_hi_sel)
    );

    assign w_dz_in  = (bus.rs2 == 32'h0) & bus.funct3[2];
    assign w_sov_in = (bus.rs1 == INT_MIN_32) & (bus.rs2 == ALL_ONES_32) &
                      bus.funct3[2] & ~bus.funct3[0];

    assign w_dp_word     = r_hi_sel ? bus.md_z[63:32] : bus.md_z[31:0];
    assign w_wait_result = (r_dz | r_sov) ? corner_result(r_is_rem, r_x, r_dz) : w_dp_word;

    // Divider error flag is redundant: corners are decided from the latched operands.
    assign w_unused_ov = bus.md_ov;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rd_d    = r_rd;
        w_err_d   = r_err;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_err_d  = 1'b0;
`ifdef MUL_DIV_SEQ_FAST_CORNER_EN
                    if (w_dz_in | w_sov_in) begin
                        w_state_d = StDone;
                        w_rd_d    = corner_result(bus.funct3[1], bus.rs1, w_dz_in);
                    end else begin
                        w_state_d = StIssue;
                    end
`else
                    w_state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                w_cnt_d   = '0;
                w_state_d = StWait;
            end
            StWait: begin
                // A completion landing on the timeout cycle still counts as success.
                if (bus.md_enable_out) begin
                    w_rd_d    = w_wait_result;
                    w_err_d   = 1'b0;
                    w_state_d = StDone;
                end else if (r_cnt == CntMax) begin
                    w_rd_d    = 32'h0;
                    w_err_d   = 1'b1;
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_rd         <= 32'h0;
            r_err        <= 1'b0;
            r_x          <= 32'h0;
            r_y          <= 32'h0;
            r_mul0_div1  <= 1'b0;
            r_x_unsigned <= 1'b0;
            r_y_unsigned <= 1'b0;
            r_hi_sel     <= 1'b0;
            r_is_rem     <= 1'b0;
            r_dz         <= 1'b0;
            r_sov        <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rd    <= w_rd_d;
            r_err   <= w_err_d;
            if (w_accept) begin
                r_x          <= bus.rs1;
                r_y          <= bus.rs2;
                r_mul0_div1  <= w_mul0_div1;
                r_x_unsigned <= w_x_unsigned;
                r_y_unsigned <= w_y_unsigned;
                r_hi_sel     <= w_hi_sel;
                r_is_rem     <= bus.funct3[1];
                r_dz         <= w_dz_in;
                r_sov        <= w_sov_in;
            end
        end
    end

    assign bus.ready                  = (r_state == StIdle);
    assign bus.done                   = (r_state == StDone);
    assign bus.md_enable_in           = (r_state == StIssue);
    assign bus.rd                     = r_rd;
    assign bus.err                    = r_err;
    assign bus.md_x                   = r_x;
    assign bus.md_y                   = r_y;
    assign bus.md_mul0_div1           = r_mul0_div1;
    assign bus.md_x_signed0_unsigned1 = r_x_unsigned;
    assign bus.md_y_signed0_unsigned1 = r_y_unsigned;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq with a behavioural mul_div_32 stub (mul 3 cycles, div 5).
module tb_mul_div_seq;

    localparam int MulLat = 3;
    localparam int DivLat = 5;

    logic clk;
    logic reset;
    mul_div_seq_if bus ();

    mul_div_seq #(
        .TIMEOUT_CYCLES (8),
        .CNT_WIDTH      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          issues;
        int          t0;
        int          n0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   n_issue;

    // Datapath stub
    int          dp_cnt;
    logic [63:0] dp_z;
    logic        stub_mute;
    logic        stale_pulse;

    function automatic logic [63:0] dp_calc(input logic [31:0] x, input logic [31:0] y,
                                            input logic div, input logic xu, input logic yu);
        logic signed [32:0] xe, ye;
        logic signed [65:0] p;
        if (!div) begin
            xe = xu ? {1'b0, x} : {x[31], x};
            ye = yu ? {1'b0, y} : {y[31], y};
            p  = xe * ye;
            return p[63:0];
        end
        if (y == 32'h0 || (!xu && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
            return 64'hDEAD_BEEF_DEAD_BEEF;
        if (xu)
            return {x / y, x % y};
        return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            dp_cnt <= 0;
        end else if (bus.md_enable_in && !stub_mute) begin
            dp_cnt <= bus.md_mul0_div1 ? DivLat : MulLat;
            dp_z   <= dp_calc(bus.md_x, bus.md_y, bus.md_mul0_div1,
                              bus.md_x_signed0_unsigned1, bus.md_y_signed0_unsigned1);
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
        end
    end

    assign bus.md_enable_out = (dp_cnt == 1) || stale_pulse;
    assign bus.md_z          = dp_z;
    assign bus.md_ov         = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.md_enable_in) n_issue++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done with rd=%h, expected no done", bus.rd);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, ".rd"}, bus.rd, mon_e.rd);
                check({mon_e.name, ".err"}, 32'(bus.err), 32'(mon_e.err));
                check({mon_e.name, ".latency"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
                check({mon_e.name, ".issues"}, 32'(n_issue - mon_e.n0), 32'(mon_e.issues));
            end
        end
    end

    // Cycle distance from start-sampling edge to done, i.e. spec latency minus one.
    function automatic int norm_lat(input logic [2:0] f3);
        return f3[2] ? (2 + DivLat) : (2 + MulLat);
    endfunction

    task automatic start_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_rd, input logic exp_err,
                            input int lat, input int issues);
        exp_t e;
        for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
        e.name   = name;
        e.rd     = exp_rd;
        e.err    = exp_err;
        e.lat    = lat;
        e.issues = issues;
        e.t0     = cyc;
        e.n0     = n_issue;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got no done within 40 cycles, expected done", name);
            sb.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd);
        start_op(name, f3, a, b, exp_rd, 1'b0, norm_lat(f3), 1);
        wait_empty(name);
    endtask

    task automatic run_corner(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_rd);
`ifdef MUL_DIV_SEQ_FAST_CORNER_EN
        start_op(name, f3, a, b, exp_rd, 1'b0, 1, 0);
`else
        start_op(name, f3, a, b, exp_rd, 1'b0, norm_lat(f3), 1);
`endif
        wait_empty(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        cyc         = 0;
        n_issue     = 0;
        dp_cnt      = 0;
        dp_z        = 64'h0;
        stub_mute   = 1'b0;
        stale_pulse = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.funct3  = 3'b000;
        bus.rs1     = 32'h0;
        bus.rs2     = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset.ready", 32'(bus.ready), 32'd1);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.md_enable_in", 32'(bus.md_enable_in), 32'd0);
        check("reset.rd", bus.rd, 32'h0);
        check("reset.err", 32'(bus.err), 32'd0);
        check("reset.md_x", bus.md_x, 32'h0);

        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
        run_op("divu_intmin_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        run_corner("divu_by0", 3'b101, 32'd100, 32'h0, 32'hFFFF_FFFF);
        run_corner("remu_by0", 3'b111, 32'd100, 32'h0, 32'd100);
        run_corner("div_by0", 3'b100, 32'd5, 32'h0, 32'hFFFF_FFFF);
        run_corner("rem_by0", 3'b110, 32'd5, 32'h0, 32'd5);
        run_corner("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_corner("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Watchdog: ISSUE edge, then 8 WAIT cycles before DONE.
        stub_mute = 1'b1;
        start_op("timeout", 3'b000, 32'd6, 32'd7, 32'h0, 1'b1, 10, 1);
        wait_empty("timeout");
        stub_mute = 1'b0;
        run_op("after_timeout", 3'b000, 32'd6, 32'd7, 32'd42);

        // Starts while busy must be dropped.
        start_op("busy", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, norm_lat(3'b000), 1);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.rs1    = 32'd9;
        bus.rs2    = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty("busy");
        repeat (12) @(negedge clk);

        // Reset mid-WAIT drops the op silently.
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.rs1    = 32'd100;
        bus.rs2    = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset.ready", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("wait_reset.ready", 32'(bus.ready), 32'd1);
        check("wait_reset.done", 32'(bus.done), 32'd0);
        check("wait_reset.rd", bus.rd, 32'h0);
        repeat (12) @(negedge clk);

        // Stray completion pulse in IDLE must not produce a done.
        stale_pulse = 1'b1;
        @(negedge clk);
        stale_pulse = 1'b0;
        check("stale.done", 32'(bus.done), 32'd0);
        check("stale.ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        check("stale.done2", 32'(bus.done), 32'd0);
        run_op("after_stale", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
